// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART serial receiver
//
// Recovers start / data / (optional parity) / stop framing from an idle-high
// serial line.  The FSM advances only on sample_tick, samples each bit at its
// centre and presents the received word with a one-cycle valid strobe.
//
// Optional feature macro: RX_PARITY_EN
//   defined   -> one even-parity bit between the last data bit and the stop bit
//   undefined -> no parity bit, parity_err tied low (port list unchanged)
//
// Parameters:
//   DATA_SIZE   data bits per frame (1..16), LSB first
//   OVERSAMPLE  sample_tick pulses per bit period (even, >= 4)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   sample_tick  one-cycle enable at OVERSAMPLE x baud
//   data_in      serial line (idle high, asynchronous to clk)
//   d_o          last received word, held until the next completed frame
//   valid        one-cycle pulse when d_o / frame_err / parity_err update
//   frame_err    stop bit sampled low on the last frame
//   parity_err   even-parity mismatch on the last frame
//   busy         high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_SIZE  = 7,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 data_in,
    output logic [DATA_SIZE-1:0] d_o,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_SIZE-1:0] shift_q;
`ifdef RX_PARITY_EN
    logic                 par_q;
`endif

    // Shift right, new bit enters at the MSB so the first (LSB) bit ends at
    // bit 0 after DATA_SIZE shifts. Written this way to stay legal for DATA_SIZE = 1.
    function automatic logic [DATA_SIZE-1:0] shift_in(input logic [DATA_SIZE-1:0] s,
                                                      input logic                 b);
        logic [DATA_SIZE-1:0] r;
        r                = s >> 1;
        r[DATA_SIZE-1]   = b;
        return r;
    endfunction

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], data_in};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= WAIT_HIGH;
            cnt        <= '0;
            idx        <= '0;
            shift_q    <= '0;
`ifdef RX_PARITY_EN
            par_q      <= 1'b0;
`endif
            d_o        <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (sample_tick) begin
                case (state)
                    // Post-reset / post-break: require one high sample before arming.
                    WAIT_HIGH: begin
                        if (rx_s) state <= IDLE;
                    end
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    // Re-check the line at the start-bit centre to reject glitches.
                    START: begin
                        if (cnt == HALF_M1) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                idx   <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == FULL_M1) begin
                            cnt     <= '0;
                            shift_q <= shift_in(shift_q, rx_s);
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
`ifdef RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef RX_PARITY_EN
                    PARITY: begin
                        if (cnt == FULL_M1) begin
                            cnt   <= '0;
                            par_q <= rx_s;
                            state <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (cnt == FULL_M1) begin
                            cnt        <= '0;
                            d_o        <= shift_q;
                            frame_err  <= ~rx_s;
`ifdef RX_PARITY_EN
                            parity_err <= (^shift_q) ^ par_q;
`else
                            parity_err <= 1'b0;
`endif
                            valid      <= 1'b1;
                            busy       <= 1'b0;
                            // A low stop bit is treated as a line break.
                            state      <= rx_s ? IDLE : WAIT_HIGH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= WAIT_HIGH;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx
// DATA_SIZE = 7, OVERSAMPLE = 16, sample_tick one clk in every four, so one
// bit period is 64 clk cycles. Parity checks are included when RX_PARITY_EN
// is defined for the build.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DW      = 7;
    localparam int OS      = 16;
    localparam int BIT_CLK = OS * 4;

    logic          clk;
    logic          reset;
    logic          sample_tick;
    logic          data_in;
    logic [DW-1:0] d_o;
    logic          valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    int tests = 0;
    int fails = 0;

    // Monitor state
    int            vcount    = 0;
    int            wide      = 0;
    logic          valid_prev = 1'b0;
    logic          busy_seen = 1'b0;
    logic [DW-1:0] last_d    = '0;
    logic          last_fe   = 1'b0;
    logic          last_pe   = 1'b0;
    int            v0;

    logic [1:0]    tdiv = 2'd0;

    uart_rx #(.DATA_SIZE(DW), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .data_in    (data_in),
        .d_o        (d_o),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial sample_tick = 1'b0;
    always @(posedge clk) begin
        tdiv        <= tdiv + 2'd1;
        sample_tick <= (tdiv == 2'd3);
    end

    always @(negedge clk) begin
        if (valid) begin
            vcount  = vcount + 1;
            last_d  = d_o;
            last_fe = frame_err;
            last_pe = parity_err;
        end
        if (valid && valid_prev) wide = wide + 1;
        valid_prev = valid;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_bits(input logic b, input int nbits);
        data_in = b;
        repeat (nbits * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
        hold_bits(1'b0, 1);
        for (int i = 0; i < DW; i++) hold_bits(d[i], 1);
`ifdef RX_PARITY_EN
        hold_bits(par, 1);
`else
        if (par) begin end
`endif
        hold_bits(stop, 1);
    endtask

    initial begin
        reset   = 1'b0;
        data_in = 1'b1;
        #1;
        check("rst_d_o",   32'(d_o),        32'h0);
        check("rst_valid", 32'(valid),      32'h0);
        check("rst_fe",    32'(frame_err),  32'h0);
        check("rst_pe",    32'(parity_err), 32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        hold_bits(1'b1, 2);

        // Basic frame 7'h57
        v0 = vcount;
        send_frame(7'h57, 1'b1, 1'b1);
        check("f57_vcnt", 32'(vcount - v0), 32'd1);
        check("f57_d",    32'(last_d),      32'h57);
        check("f57_fe",   32'(last_fe),     32'h0);
        check("f57_pe",   32'(last_pe),     32'h0);
        check("f57_busy", 32'(busy),        32'h0);
        hold_bits(1'b1, 1);

        // False start: 3 ticks low then high
        v0        = vcount;
        busy_seen = 1'b0;
        data_in   = 1'b0;
        repeat (12) @(negedge clk);
        hold_bits(1'b1, 2);
        check("fs_busy_seen", 32'(busy_seen),   32'h1);
        check("fs_busy",      32'(busy),        32'h0);
        check("fs_vcnt",      32'(vcount - v0), 32'd0);
        check("fs_d",         32'(d_o),         32'h57);

        // Framing error then line break
        v0 = vcount;
        send_frame(7'h2A, 1'b1, 1'b0);
        check("fe_vcnt", 32'(vcount - v0), 32'd1);
        check("fe_d",    32'(last_d),      32'h2A);
        check("fe_fe",   32'(last_fe),     32'h1);
        hold_bits(1'b0, 5);
        check("brk_vcnt", 32'(vcount - v0), 32'd1);
        check("brk_busy", 32'(busy),        32'h0);
        hold_bits(1'b1, 2);
        send_frame(7'h01, 1'b1, 1'b1);
        check("rec_vcnt", 32'(vcount - v0), 32'd2);
        check("rec_d",    32'(last_d),      32'h01);
        check("rec_fe",   32'(last_fe),     32'h0);
        hold_bits(1'b1, 1);

`ifdef RX_PARITY_EN
        send_frame(7'h57, 1'b1, 1'b1);
        check("par_ok_pe", 32'(last_pe), 32'h0);
        check("par_ok_d",  32'(last_d),  32'h57);
        send_frame(7'h57, 1'b0, 1'b1);
        check("par_bad_pe", 32'(last_pe), 32'h1);
        check("par_bad_d",  32'(last_d),  32'h57);
        hold_bits(1'b1, 1);
`endif

        // Reset during data bit 3 of 7'h2A (bits 0,1,0,1)
        v0 = vcount;
        hold_bits(1'b0, 1);
        hold_bits(1'b0, 1);
        hold_bits(1'b1, 1);
        hold_bits(1'b0, 1);
        data_in = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        check("mid_busy", 32'(busy), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("arst_d",    32'(d_o),        32'h0);
        check("arst_fe",   32'(frame_err),  32'h0);
        check("arst_busy", 32'(busy),       32'h0);
        check("arst_valid", 32'(valid),     32'h0);
        data_in = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        hold_bits(1'b1, 2);
        check("arst_vcnt", 32'(vcount - v0), 32'd0);
        send_frame(7'h2A, 1'b1, 1'b1);
        check("post_rst_vcnt", 32'(vcount - v0), 32'd1);
        check("post_rst_d",    32'(last_d),      32'h2A);

        // Back-to-back frames, no idle gap
        v0 = vcount;
        send_frame(7'h00, 1'b0, 1'b1);
        check("b2b0_d",  32'(last_d),  32'h00);
        check("b2b0_fe", 32'(last_fe), 32'h0);
        send_frame(7'h7F, 1'b1, 1'b1);
        check("b2b1_d",    32'(last_d),      32'h7F);
        check("b2b1_fe",   32'(last_fe),     32'h0);
        check("b2b_vcnt",  32'(vcount - v0), 32'd2);
        hold_bits(1'b1, 1);

        check("valid_width", 32'(wide), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver stage of the UART: consumes the line driven by `tx` (or an external pin), recovers start/data/stop framing with OVERSAMPLE-times oversampling and mid-bit sampling, and presents each received word on a parallel port with a one-cycle valid strobe. It is driven by the same `sample_tick` produced by the shared baud generator and sits directly downstream of `tx` in loopback builds.

## Interface
Parameters:
- DATA_SIZE, 7, data bits per frame (1..16), LSB transmitted first
- OVERSAMPLE, 16, sample_tick pulses per bit period; even, >= 4

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset (low = reset asserted); one clock domain only
- sample_tick  input  1  single-clk-cycle enable pulse at OVERSAMPLE × baud rate
- data_in  input  1  serial line, idle high, asynchronous to clk
- d_o  output  DATA_SIZE  last received word, held until next completed frame
- valid  output  1  one-cycle pulse when d_o/frame_err/parity_err update
- frame_err  output  1  stop bit sampled low on last frame; held with d_o
- parity_err  output  1  parity mismatch on last frame; held with d_o; constant 0 when parity disabled
- busy  output  1  high while a frame is being received (START, DATA, PARITY, STOP)

## Operation
- data_in passes through a 2-flop synchronizer (reset value 1) → rx_s; all decisions use rx_s.
- FSM advances only in cycles where sample_tick = 1; tick counter cnt is log2(OVERSAMPLE) bits, bit index sized for DATA_SIZE.
- States:
  - WAIT_HIGH: reset state and post-error state. On tick with rx_s = 1 → IDLE.
  - IDLE: on tick with rx_s = 0 → START, cnt = 0.
  - START: on tick cnt++; at cnt = OVERSAMPLE/2 − 1 (start-bit centre): rx_s = 0 → DATA, cnt = 0, idx = 0; rx_s = 1 → IDLE (false start, no valid).
  - DATA: on tick cnt++; at cnt = OVERSAMPLE − 1: shift rx_s into MSB of shift register (shift right), cnt = 0, idx++; after bit DATA_SIZE−1 → PARITY (macro on) or STOP.
  - PARITY: same bit timing; sample parity bit.
  - STOP: same bit timing; at sample: d_o ← shift register, frame_err ← ~rx_s, parity_err ← (^shift ^ parity bit) (even parity), valid = 1 for next cycle. Stop = 1 → IDLE; stop = 0 → WAIT_HIGH (line break: no new frame until line returns high).
- d_o is updated on every completed frame, including errored ones.
- busy = 1 exactly in START, DATA, PARITY, STOP.

## Timing
- Reset (async, reset = 0): d_o = 0, valid = 0, frame_err = 0, parity_err = 0, busy = 0, sync flops = 1, FSM = WAIT_HIGH, counters = 0. Effect immediate, independent of clk.
- Reset mid-frame aborts with no valid; receiver re-arms only after one tick with rx_s = 1.
- Input latency: 2 clk cycles through synchronizer.
- Start detection to sample of bit k (0-based data): OVERSAMPLE/2 + (k+1)·OVERSAMPLE ticks after the detecting tick.
- valid asserts in the clk cycle after the tick that samples the stop bit, for exactly one cycle; busy falls the same cycle.
- Back-to-back frames: a start bit immediately following a valid stop bit is detected on the next tick; no idle time required.
- sample_tick held high for multiple cycles counts once per cycle (the generator must pulse).

## Configuration
- RX_PARITY_EN defined: one even-parity bit expected between last data bit and stop bit (PARITY state present, frame = DATA_SIZE + 3 bits); parity_err reports mismatch.
- RX_PARITY_EN undefined: PARITY state omitted, DATA → STOP directly, parity_err tied to 0; port list unchanged.

## Test plan
(DATA_SIZE = 7, OVERSAMPLE = 16, 1-clk sample_tick every 4 clks.)
- Frame 7'h57 (bits 1,1,1,0,1,0,1 LSB first), stop = 1 → d_o = 7'h57, valid one cycle, frame_err = 0, busy low after.
- Line low for 3 ticks then high → returns to IDLE, busy pulses then falls, no valid, d_o unchanged.
- Frame 7'h2A with stop = 0, line then held low 5 bit times → valid, d_o = 7'h2A, frame_err = 1; no further valid until line high then new frame 7'h01 → d_o = 7'h01, frame_err = 0.
- RX_PARITY_EN: 7'h57 with parity bit 1 → parity_err = 0; same with parity bit 0 → parity_err = 1, d_o = 7'h57.
- Reset asserted during data bit 3 → all outputs 0 immediately, no valid; release with line high, send 7'h2A → d_o = 7'h2A.
- Frames 7'h00 and 7'h7F back-to-back, no idle gap → two valid pulses, d_o = 7'h00 then 7'h7F, both frame_err = 0.
